// File: rtl/pipemem_ctrl_if.sv
// EX/MEM operands, external data-bus handshake and MEM/WB-side results of the
// MEM-stage memory controller, bundled for a single port connection.
interface pipemem_ctrl_if;
    logic        mvalid;
    logic [31:0] malu;
    logic [31:0] mb;
    logic        mwreg;
    logic        mm2reg;
    logic        mwmem;
    logic [1:0]  msize;
    logic        msigned;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] mmo;
    logic        mwreg_o;
    logic        mm2reg_o;
    logic        stall;
    logic        merr;

    // master: the controller itself
    modport master (
        input  mvalid, malu, mb, mwreg, mm2reg, mwmem, msize, msigned,
        input  dm_rdata, dm_ack,
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output mmo, mwreg_o, mm2reg_o, stall, merr
    );

    // slave: pipeline plus memory side surrounding the controller
    modport slave (
        output mvalid, malu, mb, mwreg, mm2reg, mwmem, msize, msigned,
        output dm_rdata, dm_ack,
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  mmo, mwreg_o, mm2reg_o, stall, merr
    );
endinterface

// File: rtl/pipemem_ctrl.sv
// MEM-stage data-memory controller: stalls the pipeline across a variable-latency
// req/ack bus transaction, extracts/extends load lanes and flags misaligned or timed-out accesses.
module pipemem_ctrl #(
    parameter int unsigned TMO = 255
) (
    input  logic           clk,
    input  logic           clr,
    pipemem_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t      state_reg;
    logic [7:0]  cnt_reg;
    logic        req_reg, we_reg, merr_reg;
    logic [31:0] addr_reg, wdata_reg, mmo_reg;
    logic [3:0]  be_reg;
    logic [1:0]  size_reg, lane_reg;
    logic        sign_reg, load_reg;

    logic        acc, misaligned, start;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    always_comb begin
        acc        = bus.mvalid & (bus.mm2reg | bus.mwmem);
        misaligned = ((bus.msize == 2'b01) & bus.malu[0]) |
                     (bus.msize[1] & (bus.malu[1:0] != 2'b00));
        start      = (state_reg == IDLE) & acc & ~misaligned;
        be_next    = 4'b1111;
        wdata_next = bus.mb;
        case (bus.msize)
            2'b00: begin
                be_next    = 4'b0001 << bus.malu[1:0];
                wdata_next = {4{bus.mb[7:0]}};
            end
            2'b01: begin
                be_next    = bus.malu[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{bus.mb[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane extraction uses the size/sign/lane captured at request time, not the live EX/MEM fields.
    always_comb begin
        byte_sel = bus.dm_rdata[{lane_reg, 3'b000} +: 8];
        half_sel = lane_reg[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
        case (size_reg)
            2'b00:   load_ext = {{24{sign_reg & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{sign_reg & half_sel[15]}}, half_sel};
            default: load_ext = bus.dm_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            merr_reg  <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            mmo_reg   <= 32'd0;
            be_reg    <= 4'd0;
            size_reg  <= 2'd0;
            lane_reg  <= 2'd0;
            sign_reg  <= 1'b0;
            load_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        req_reg   <= 1'b1;
                        we_reg    <= bus.mwmem;
                        addr_reg  <= {bus.malu[31:2], 2'b00};
                        be_reg    <= be_next;
                        wdata_reg <= wdata_next;
                        size_reg  <= bus.msize;
                        sign_reg  <= bus.msigned;
                        lane_reg  <= bus.malu[1:0];
                        load_reg  <= bus.mm2reg;
                        cnt_reg   <= 8'd0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + 8'd1;
                    // An ack landing on the last allowed cycle still wins over the timeout.
                    if (bus.dm_ack) begin
                        if (load_reg) mmo_reg <= load_ext;
                        req_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        state_reg <= DONE;
                    end else if (cnt_reg == TMO_LAST) begin
                        req_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        merr_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    merr_reg  <= 1'b0;
                    cnt_reg   <= 8'd0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.dm_req   = req_reg;
        bus.dm_we    = we_reg;
        bus.dm_addr  = addr_reg;
        bus.dm_be    = be_reg;
        bus.dm_wdata = wdata_reg;
        bus.mmo      = mmo_reg;
        bus.stall    = start | (state_reg == BUSY);
        bus.merr     = merr_reg | ((state_reg == IDLE) & acc & misaligned);
        bus.mwreg_o  = 1'b0;
        bus.mm2reg_o = 1'b0;
        case (state_reg)
            IDLE: bus.mwreg_o = bus.mvalid & bus.mwreg & ~acc;
            DONE: begin
                bus.mwreg_o  = bus.mwreg & ~merr_reg;
                bus.mm2reg_o = bus.mm2reg & ~merr_reg;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pipemem_ctrl.sv
// Table-driven bench for pipemem_ctrl (TMO=4): each record is one EX/MEM instruction with
// its bus reply cycle and the hand-computed stall length, bus fields and MEM/WB results.
module tb_pipemem_ctrl;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipemem_ctrl_if bus ();

    pipemem_ctrl #(.TMO(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mvalid;
        logic [31:0] malu;
        logic [31:0] mb;
        logic        mwreg, mm2reg, mwmem;
        logic [1:0]  msize;
        logic        msigned;
        logic [31:0] rdata;
        int          ack_at;
        int          stall_n;
        int          req_n;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] mmo;
        logic        mwreg_o, mm2reg_o, merr;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(
        input logic mvalid, input logic [31:0] malu, input logic [31:0] mb,
        input logic mwreg, input logic mm2reg, input logic mwmem,
        input logic [1:0] msize, input logic msigned, input logic [31:0] rdata,
        input int ack_at, input int stall_n, input int req_n,
        input logic [31:0] addr, input logic [3:0] be, input logic we,
        input logic [31:0] wdata, input logic [31:0] mmo,
        input logic mwreg_o, input logic mm2reg_o, input logic merr);
        vec_t v;
        v.mvalid = mvalid; v.malu = malu; v.mb = mb;
        v.mwreg = mwreg; v.mm2reg = mm2reg; v.mwmem = mwmem;
        v.msize = msize; v.msigned = msigned; v.rdata = rdata;
        v.ack_at = ack_at; v.stall_n = stall_n; v.req_n = req_n;
        v.addr = addr; v.be = be; v.we = we; v.wdata = wdata; v.mmo = mmo;
        v.mwreg_o = mwreg_o; v.mm2reg_o = mm2reg_o; v.merr = merr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.mvalid = 1'b0; bus.malu = 32'd0; bus.mb = 32'd0;
        bus.mwreg = 1'b0; bus.mm2reg = 1'b0; bus.mwmem = 1'b0;
        bus.msize = 2'd0; bus.msigned = 1'b0; bus.dm_rdata = 32'd0; bus.dm_ack = 1'b0;
    endtask

    // Entered at posedge+1; returns at posedge+1 of the cycle after the non-stalled one.
    task automatic run_vec(input int idx, input vec_t v);
        int stall_cycles = 0;
        int busy_idx     = 0;
        bus.mvalid = v.mvalid; bus.malu = v.malu; bus.mb = v.mb;
        bus.mwreg = v.mwreg; bus.mm2reg = v.mm2reg; bus.mwmem = v.mwmem;
        bus.msize = v.msize; bus.msigned = v.msigned; bus.dm_rdata = v.rdata;
        bus.dm_ack = 1'b0;
        @(negedge clk);
        while (bus.stall === 1'b1 && stall_cycles < 50) begin
            stall_cycles++;
            if (bus.dm_req === 1'b1) begin
                busy_idx++;
                check($sformatf("v%0d dm_addr", idx), bus.dm_addr, v.addr);
                check($sformatf("v%0d dm_be", idx), {28'd0, bus.dm_be}, {28'd0, v.be});
                check($sformatf("v%0d dm_we", idx), {31'd0, bus.dm_we}, {31'd0, v.we});
                check($sformatf("v%0d dm_wdata", idx), bus.dm_wdata, v.wdata);
                bus.dm_ack = (busy_idx == v.ack_at);
            end
            @(posedge clk); #1;
            bus.dm_ack = 1'b0;
            @(negedge clk);
        end
        check($sformatf("v%0d stall_len", idx), stall_cycles, v.stall_n);
        check($sformatf("v%0d req_cycles", idx), busy_idx, v.req_n);
        check($sformatf("v%0d dm_req_end", idx), {31'd0, bus.dm_req}, 32'd0);
        check($sformatf("v%0d mwreg_o", idx), {31'd0, bus.mwreg_o}, {31'd0, v.mwreg_o});
        check($sformatf("v%0d mm2reg_o", idx), {31'd0, bus.mm2reg_o}, {31'd0, v.mm2reg_o});
        check($sformatf("v%0d merr", idx), {31'd0, bus.merr}, {31'd0, v.merr});
        check($sformatf("v%0d mmo", idx), bus.mmo, v.mmo);
        $display("vec %0d: malu=0x%08h size=%0d stall=%0d mmo=0x%08h mwreg_o=%0b merr=%0b",
                 idx, v.malu, v.msize, stall_cycles, bus.mmo, bus.mwreg_o, bus.merr);
        @(posedge clk); #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            mv malu       mb           wr ld st sz sg rdata         ack st rq addr      be    we wdata          mmo           wo lo er
        vecs[0]  = mk(1, 32'h100, 32'h0,        1, 1, 0, 2, 0, 32'hDEADBEEF, 3, 4, 3, 32'h100, 4'hF, 0, 32'h0,        32'hDEADBEEF, 1, 1, 0);
        vecs[1]  = mk(1, 32'h203, 32'h0,        1, 1, 0, 0, 1, 32'h80112233, 1, 2, 1, 32'h200, 4'h8, 0, 32'h0,        32'hFFFFFF80, 1, 1, 0);
        vecs[2]  = mk(1, 32'h203, 32'h0,        1, 1, 0, 0, 0, 32'h80112233, 2, 3, 2, 32'h200, 4'h8, 0, 32'h0,        32'h00000080, 1, 1, 0);
        vecs[3]  = mk(1, 32'h302, 32'hABCD,     0, 0, 1, 1, 0, 32'h0,        1, 2, 1, 32'h300, 4'hC, 1, 32'hABCDABCD, 32'h00000080, 0, 0, 0);
        vecs[4]  = mk(1, 32'h101, 32'h0,        1, 1, 0, 2, 0, 32'h0,        0, 0, 0, 32'h0,   4'h0, 0, 32'h0,        32'h00000080, 0, 0, 1);
        vecs[5]  = mk(1, 32'h104, 32'h0,        1, 1, 0, 2, 0, 32'h12345678, 0, 5, 4, 32'h104, 4'hF, 0, 32'h0,        32'h00000080, 0, 0, 1);
        vecs[6]  = mk(1, 32'h0,   32'h0,        1, 0, 0, 2, 0, 32'h0,        0, 0, 0, 32'h0,   4'h0, 0, 32'h0,        32'h00000080, 1, 0, 0);
        vecs[7]  = mk(1, 32'h206, 32'h0,        1, 1, 0, 1, 1, 32'h80017FFF, 2, 3, 2, 32'h204, 4'hC, 0, 32'h0,        32'hFFFF8001, 1, 1, 0);
        vecs[8]  = mk(1, 32'h204, 32'h0,        1, 1, 0, 1, 0, 32'h8001F00D, 1, 2, 1, 32'h204, 4'h3, 0, 32'h0,        32'h0000F00D, 1, 1, 0);
        vecs[9]  = mk(1, 32'h101, 32'h1234565A, 0, 0, 1, 0, 0, 32'h0,        1, 2, 1, 32'h100, 4'h2, 1, 32'h5A5A5A5A, 32'h0000F00D, 0, 0, 0);
        vecs[10] = mk(1, 32'h10C, 32'hCAFEF00D, 0, 0, 1, 3, 0, 32'h0,        4, 5, 4, 32'h10C, 4'hF, 1, 32'hCAFEF00D, 32'h0000F00D, 0, 0, 0);
        vecs[11] = mk(0, 32'h100, 32'h0,        1, 1, 0, 2, 0, 32'h0,        0, 0, 0, 32'h0,   4'h0, 0, 32'h0,        32'h0000F00D, 0, 0, 0);
        vecs[12] = mk(1, 32'h108, 32'h0,        1, 1, 0, 3, 0, 32'h11223344, 1, 2, 1, 32'h108, 4'hF, 0, 32'h0,        32'h11223344, 1, 1, 0);
        vecs[13] = mk(1, 32'h303, 32'hFFFF,     0, 0, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0,   4'h0, 0, 32'h0,        32'h11223344, 0, 0, 1);

        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst dm_req", {31'd0, bus.dm_req}, 32'd0);
        check("rst dm_we", {31'd0, bus.dm_we}, 32'd0);
        check("rst dm_addr", bus.dm_addr, 32'd0);
        check("rst dm_be", {28'd0, bus.dm_be}, 32'd0);
        check("rst dm_wdata", bus.dm_wdata, 32'd0);
        check("rst mmo", bus.mmo, 32'd0);
        check("rst merr", {31'd0, bus.merr}, 32'd0);
        check("rst stall", {31'd0, bus.stall}, 32'd0);
        clr = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Stray ack while idle must not start anything.
        drive_idle();
        bus.dm_ack = 1'b1;
        @(posedge clk); #1;
        bus.dm_ack = 1'b0;
        @(negedge clk);
        check("idle_ack dm_req", {31'd0, bus.dm_req}, 32'd0);
        check("idle_ack stall", {31'd0, bus.stall}, 32'd0);
        check("idle_ack mmo", bus.mmo, 32'h11223344);
        $display("idle stray ack: dm_req=%0b stall=%0b", bus.dm_req, bus.stall);
        @(posedge clk); #1;

        // Async clear in the second BUSY cycle of a load, then a stray ack.
        bus.mvalid = 1'b1; bus.malu = 32'h100; bus.mwreg = 1'b1; bus.mm2reg = 1'b1;
        bus.msize = 2'd2; bus.dm_rdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("clr pre dm_req", {31'd0, bus.dm_req}, 32'd1);
        check("clr pre stall", {31'd0, bus.stall}, 32'd1);
        bus.mvalid = 1'b0;
        clr = 1'b1;
        #1;
        check("clr dm_req", {31'd0, bus.dm_req}, 32'd0);
        check("clr dm_addr", bus.dm_addr, 32'd0);
        check("clr dm_be", {28'd0, bus.dm_be}, 32'd0);
        check("clr mmo", bus.mmo, 32'd0);
        check("clr stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        bus.dm_ack = 1'b1;
        @(posedge clk); #1;
        bus.dm_ack = 1'b0;
        @(negedge clk);
        check("post_clr dm_req", {31'd0, bus.dm_req}, 32'd0);
        check("post_clr stall", {31'd0, bus.stall}, 32'd0);
        check("post_clr mmo", bus.mmo, 32'd0);
        $display("clear mid-busy: dm_req=%0b stall=%0b mmo=0x%08h", bus.dm_req, bus.stall, bus.mmo);
        @(posedge clk); #1;

        // State must be IDLE again: a fresh load gets the minimum two-cycle stall.
        run_vec(14, mk(1, 32'h200, 32'h0, 1, 1, 0, 2, 0, 32'h0BADCAFE, 1, 2, 1, 32'h200, 4'hF, 0,
                       32'h0, 32'h0BADCAFE, 1, 1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
